// File: rtl/reaction_timer_ctrl.sv
// Reaction-time sequencer for the F1 start-light game: arms on seq_start and times lights-out to press in ms.
// The best-time tracker is included only when BEST_TIME_EN is defined; otherwise best_ms is tied to 0.
module reaction_timer_ctrl #(
  parameter int CNT_W  = 14,
  parameter int MAX_MS = 9999,
  parameter int MIN_MS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             seq_start,
  input  logic             lights_out,
  input  logic             trigger,
  output logic [CNT_W-1:0] result_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT, TMO} state_t;

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_MS - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MS);

  state_t           state;
  logic             trig_q;
  logic [CNT_W-1:0] count;
  logic             press;

  assign press = trigger & ~trig_q;

  // NOTE: every register here is written with <= so all updates see pre-edge values,
  // which is what keeps the flags and result exactly one cycle behind their cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      trig_q       <= 1'b0;
      count        <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      trig_q <= trigger;
      if (seq_start) begin
        state        <= ARMED;
        count        <= '0;
        result_ms    <= '0;
        result_valid <= 1'b0;
        false_start  <= 1'b0;
        timeout      <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          ARMED: begin
            // A press coinciding with lights_out is still a jump start.
            if (press) begin
              state       <= FAULT;
              result_ms   <= '0;
              false_start <= 1'b1;
              busy        <= 1'b0;
            end else if (lights_out) begin
              state <= TIMING;
              count <= '0;
            end
          end
          TIMING: begin
            if (press) begin
              result_ms <= count;
              busy      <= 1'b0;
              if (count < MIN_C) begin
                state       <= FAULT;
                false_start <= 1'b1;
              end else begin
                state        <= DONE;
                result_valid <= 1'b1;
              end
            end else if (tick_ms) begin
              if (count == LAST_C) begin
                state     <= TMO;
                count     <= MAX_C;
                result_ms <= MAX_C;
                timeout   <= 1'b1;
                busy      <= 1'b0;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BEST_TIME_EN
  // Only a valid press from TIMING (the DONE entry condition) may improve the best time.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_ms <= '0;
    end else if (!seq_start && state == TIMING && press && count >= MIN_C &&
                 (best_ms == '0 || count < best_ms)) begin
      best_ms <= count;
    end
  end
`else
  assign best_ms = '0;
`endif

endmodule
